// File: rtl/deser_8_1bit_pkg.sv
// Shared constants, state encoding and helpers for the 8-bit serial-to-parallel deserializer.
package deser_8_1bit_pkg;

    localparam int DESER_W = 8;
    localparam int CNT_W   = 3;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        PARITY  = 2'd2
    } state_t;

    // Even parity: 1 when the word has an odd number of ones.
    function automatic logic even_parity(input logic [DESER_W-1:0] data);
        return ^data;
    endfunction

    function automatic logic [CNT_W-1:0] bit_pos(input logic [CNT_W-1:0] cnt, input logic lsb_first);
        return lsb_first ? cnt : (3'd7 - cnt);
    endfunction

endpackage

// File: rtl/deser_8_1bit_decoder_3_8.sv
// 3-to-8 one-hot decoder producing the shadow-register write enable.
module decoder_3_8
    import deser_8_1bit_pkg::*;
(
    input  logic [CNT_W-1:0]   idx,
    input  logic               en,
    output logic [DESER_W-1:0] onehot
);

    // One-hot decode of idx, all zero when disabled.
    always_comb begin
        onehot = {DESER_W{1'b0}};
        if (en) begin
            onehot[idx] = 1'b1;
        end else begin
            onehot = {DESER_W{1'b0}};
        end
    end

endmodule

// File: rtl/deser_8_1bit.sv
// 1-bit serial to 8-bit parallel deserializer with clear and optional parity.
// Define DESER_PARITY_EN to expect a ninth even-parity bit and expose parity_err.
module deser_8_1bit
    import deser_8_1bit_pkg::*;
#(
    parameter int LSB_FIRST = 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               in,
    input  logic               in_valid,
    input  logic               clear,
    output logic [DESER_W-1:0] out,
    output logic               out_valid,
    output logic [CNT_W-1:0]   select,
    output logic               busy
`ifdef DESER_PARITY_EN
    ,
    output logic               parity_err
`endif
);

    localparam logic LSB_S = (LSB_FIRST != 32'sd0);

    state_t             state_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_inc_s;
    logic [CNT_W-1:0]   pos_s;
    logic [CNT_W-1:0]   select_r;
    logic [DESER_W-1:0] shadow_r;
    logic [DESER_W-1:0] we_s;
    logic [DESER_W-1:0] word_s;
    logic [DESER_W-1:0] out_r;
    logic               out_valid_r;
    logic               busy_r;
    logic               write_s;
    logic               parity_err_r;

    assign cnt_inc_s = cnt_r + 3'd1;
    assign pos_s     = bit_pos(cnt_r, LSB_S);
    // The parity bit is never written into the shadow word.
    assign write_s   = in_valid & ~clear & (state_r != PARITY);

    decoder_3_8 u_decoder (
        .idx    (pos_s),
        .en     (write_s),
        .onehot (we_s)
    );

    // Shadow word with the incoming bit merged at its write position.
    always_comb begin
        word_s = shadow_r;
        for (int i = 0; i < DESER_W; i++) begin
            if (we_s[i]) begin
                word_s[i] = in;
            end else begin
                word_s[i] = shadow_r[i];
            end
        end
    end

    // Collection FSM with registered outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            cnt_r        <= 3'd0;
            select_r     <= bit_pos(3'd0, LSB_S);
            shadow_r     <= 8'h00;
            out_r        <= 8'h00;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            parity_err_r <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            if (clear) begin
                state_r  <= IDLE;
                cnt_r    <= 3'd0;
                select_r <= bit_pos(3'd0, LSB_S);
                shadow_r <= 8'h00;
                busy_r   <= 1'b0;
            end else if (in_valid) begin
                case (state_r)
                    IDLE, COLLECT: begin
                        shadow_r <= word_s;
                        cnt_r    <= cnt_inc_s;
                        select_r <= bit_pos(cnt_inc_s, LSB_S);
                        if (cnt_r == 3'd7) begin
`ifdef DESER_PARITY_EN
                            state_r <= PARITY;
                            busy_r  <= 1'b1;
`else
                            state_r     <= IDLE;
                            out_r       <= word_s;
                            out_valid_r <= 1'b1;
                            busy_r      <= 1'b0;
`endif
                        end else begin
                            state_r <= COLLECT;
                            busy_r  <= 1'b1;
                        end
                    end
`ifdef DESER_PARITY_EN
                    PARITY: begin
                        state_r      <= IDLE;
                        out_r        <= shadow_r;
                        out_valid_r  <= 1'b1;
                        parity_err_r <= even_parity(shadow_r) ^ in;
                        busy_r       <= 1'b0;
                    end
`endif
                    default: begin
                        state_r  <= IDLE;
                        cnt_r    <= 3'd0;
                        select_r <= bit_pos(3'd0, LSB_S);
                        busy_r   <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign out       = out_r;
    assign out_valid = out_valid_r;
    assign select    = select_r;
    assign busy      = busy_r;
`ifdef DESER_PARITY_EN
    assign parity_err = parity_err_r;
`endif

endmodule

// File: tb/tb_deser_8_1bit.sv
// Self-checking bench: LSB-first and MSB-first instances on a shared stream, checked against a queue model.
module tb_deser_8_1bit;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       in = 1'b0;
    logic       in_valid = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] out1, out0;
    logic       ov1, ov0, busy1, busy0;
    logic [2:0] sel1, sel0;
    logic       perr1, perr0;

    int total = 0;
    int passed = 0;
    int failed = 0;

    bit         q[$];
    bit         pending = 1'b0;
    logic [7:0] exp1 = 8'h00;
    logic [7:0] exp0 = 8'h00;
    logic       exp_valid = 1'b0;
    logic       exp_perr = 1'b0;

    always #5 clock = ~clock;

`ifdef DESER_PARITY_EN
    deser_8_1bit #(.LSB_FIRST(1)) dut1 (.clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
        .clear(clear), .out(out1), .out_valid(ov1), .select(sel1), .busy(busy1), .parity_err(perr1));
    deser_8_1bit #(.LSB_FIRST(0)) dut0 (.clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
        .clear(clear), .out(out0), .out_valid(ov0), .select(sel0), .busy(busy0), .parity_err(perr0));
`else
    deser_8_1bit #(.LSB_FIRST(1)) dut1 (.clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
        .clear(clear), .out(out1), .out_valid(ov1), .select(sel1), .busy(busy1));
    deser_8_1bit #(.LSB_FIRST(0)) dut0 (.clock(clock), .reset(reset), .in(in), .in_valid(in_valid),
        .clear(clear), .out(out0), .out_valid(ov0), .select(sel0), .busy(busy0));
    assign perr1 = 1'b0;
    assign perr0 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word assembled from the queued bits; msb_first puts the first bit at bit 7.
    function automatic logic [7:0] model_word(input bit msb_first);
        logic [7:0] w = 8'h00;
        for (int k = 0; k < 8; k++) begin
            if (msb_first) w[7-k] = q[k];
            else           w[k]   = q[k];
        end
        return w;
    endfunction

    task automatic model_step(input logic b, input logic v, input logic c);
        exp_valid = 1'b0;
        if (c) begin
            q.delete();
            pending = 1'b0;
        end else if (v) begin
            if (pending) begin
                exp1      = model_word(1'b0);
                exp0      = model_word(1'b1);
                exp_perr  = (^exp1) ^ b;
                exp_valid = 1'b1;
                pending   = 1'b0;
                q.delete();
            end else begin
                q.push_back(b);
                if (q.size() == 8) begin
`ifdef DESER_PARITY_EN
                    pending = 1'b1;
`else
                    exp1      = model_word(1'b0);
                    exp0      = model_word(1'b1);
                    exp_valid = 1'b1;
                    q.delete();
`endif
                end
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        pending   = 1'b0;
        exp1      = 8'h00;
        exp0      = 8'h00;
        exp_valid = 1'b0;
        exp_perr  = 1'b0;
    endtask

    task automatic check_all();
        int n;
        n = q.size() % 8;
        chk("out_lsb", out1, exp1);
        chk("out_msb", out0, exp0);
        chk("valid_lsb", {7'd0, ov1}, {7'd0, exp_valid});
        chk("valid_msb", {7'd0, ov0}, {7'd0, exp_valid});
        chk("select_lsb", {5'd0, sel1}, 8'(n));
        chk("select_msb", {5'd0, sel0}, 8'(7 - n));
        chk("busy_lsb", {7'd0, busy1}, {7'd0, (q.size() != 0) || pending});
        chk("busy_msb", {7'd0, busy0}, {7'd0, (q.size() != 0) || pending});
`ifdef DESER_PARITY_EN
        chk("perr_lsb", {7'd0, perr1}, {7'd0, exp_perr});
        chk("perr_msb", {7'd0, perr0}, {7'd0, exp_perr});
`endif
    endtask

    task automatic cycle(input logic b, input logic v, input logic c);
        in       = b;
        in_valid = v;
        clear    = c;
        @(posedge clock);
        model_step(b, v, c);
        #1;
        check_all();
    endtask

    // Sends w[0] first, idle gaps between bits, then the correct parity bit if enabled.
    task automatic send_word(input logic [7:0] w, input int gap);
        for (int k = 0; k < 8; k++) begin
            cycle(w[k], 1'b1, 1'b0);
            if (k < 7) begin
                for (int g = 0; g < gap; g++) cycle(1'($urandom_range(1)), 1'b0, 1'b0);
            end
        end
`ifdef DESER_PARITY_EN
        cycle(^w, 1'b1, 1'b0);
`endif
    endtask

    initial begin
        logic [7:0] stream;
        @(posedge clock);
        #1;
        model_reset();
        check_all();
        chk("reset_sel_msb", {5'd0, sel0}, 8'd7);
        #3 reset = 1'b0;

        // Stream 1,0,1,1,0,0,1,0 in time order.
        stream = 8'b0100_1101;
        send_word(stream, 0);
        chk("stream_lsb", out1, 8'h4D);
        chk("stream_msb", out0, 8'hB2);
        chk("stream_pulse", {7'd0, ov1}, 8'd1);
        cycle(1'b0, 1'b0, 1'b0);
        chk("stream_pulse_end", {7'd0, ov1}, 8'd0);
        chk("stream_idle_busy", {7'd0, busy1}, 8'd0);

        // Gapped word then an immediate back-to-back word.
        send_word(8'hA5, 3);
        chk("gap_word", out1, 8'hA5);
        send_word(8'h3C, 0);
        chk("b2b_word", out1, 8'h3C);
        cycle(1'b0, 1'b0, 1'b0);

        // Abort after five bits with a colliding valid bit.
        for (int k = 0; k < 5; k++) cycle(1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b1);
        chk("clear_hold", out1, 8'h3C);
        chk("clear_novalid", {7'd0, ov1}, 8'd0);
        send_word(8'hFF, 0);
        chk("after_clear", out1, 8'hFF);

        // Asynchronous reset in the middle of a word.
        for (int k = 0; k < 4; k++) cycle(1'b1, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1;
        model_reset();
        chk("areset_out", out1, 8'h00);
        chk("areset_sel_lsb", {5'd0, sel1}, 8'd0);
        chk("areset_sel_msb", {5'd0, sel0}, 8'd7);
        chk("areset_busy", {7'd0, busy1}, 8'd0);
        #2 reset = 1'b0;
        send_word(8'h81, 0);
        chk("after_reset", out1, 8'h81);

`ifdef DESER_PARITY_EN
        for (int k = 0; k < 8; k++) cycle(k < 2 ? 1'b1 : 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 1'b1, 1'b0);
        chk("par_bad_out", out1, 8'h03);
        chk("par_bad_err", {7'd0, perr1}, 8'd1);
        for (int k = 0; k < 8; k++) cycle(k < 2 ? 1'b1 : 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b0);
        chk("par_ok_err", {7'd0, perr1}, 8'd0);
`endif

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(1)), ($urandom_range(99) < 70), ($urandom_range(99) < 4));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
